// File: rtl/acc_step_gen_if.sv
// rtl/acc_step_gen_if.sv - planner-to-step-generator command/status bundle.
// Optional ACC_STEP_GEN_POS_EN adds the signed position output.
interface acc_step_gen_if;
    logic        load;
    logic [31:0] dt_val;
    logic [31:0] steps_val;
    logic        step;
    logic        busy;
    logic        done;
    logic [31:0] steps_left;
`ifdef ACC_STEP_GEN_POS_EN
    logic signed [31:0] pos;
`endif

    modport master (
        output load, dt_val, steps_val,
`ifdef ACC_STEP_GEN_POS_EN
        input  pos,
`endif
        input  step, busy, done, steps_left
    );

    modport slave (
        input  load, dt_val, steps_val,
`ifdef ACC_STEP_GEN_POS_EN
        output pos,
`endif
        output step, busy, done, steps_left
    );
endinterface

// File: rtl/acc_step_gen.sv
// rtl/acc_step_gen.sv - fixed-interval step pulse generator for one motion axis.
// Optional ACC_STEP_GEN_POS_EN adds a wrapping signed step position counter.
module acc_step_gen (
    input  logic           clk,
    input  logic           reset,
    acc_step_gen_if.slave  cmd_io
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] dt_q, dt_d;
    logic [31:0] steps_q, steps_d;
    logic        step_q, step_d;
    logic        done_q, done_d;
    logic        tick;

    // A step falls due on the edge where the timer has counted a full interval.
    assign tick = (state_q == RUN) && (steps_q != 32'd0) && (timer_q == dt_q - 32'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            timer_q <= 32'd0;
            dt_q    <= 32'd0;
            steps_q <= 32'd0;
            step_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            dt_q    <= dt_d;
            steps_q <= steps_d;
            step_q  <= step_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        dt_d    = dt_q;
        steps_d = steps_q;
        step_d  = tick;
        done_d  = 1'b0;
        // Load takes priority; a step due on the same edge is still emitted.
        if (cmd_io.load) begin
            dt_d    = (cmd_io.dt_val == 32'd0) ? 32'd1 : cmd_io.dt_val;
            steps_d = cmd_io.steps_val;
            timer_d = 32'd0;
            if (cmd_io.steps_val == 32'd0) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                state_d = RUN;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    timer_d = 32'd0;
                    steps_d = 32'd0;
                end
                RUN: begin
                    if (steps_q == 32'd0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        timer_d = 32'd0;
                    end else if (tick) begin
                        timer_d = 32'd0;
                        steps_d = steps_q - 32'd1;
                    end else begin
                        timer_d = timer_q + 32'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign cmd_io.step       = step_q;
    assign cmd_io.done       = done_q;
    assign cmd_io.busy       = (state_q == RUN);
    assign cmd_io.steps_left = steps_q;

`ifdef ACC_STEP_GEN_POS_EN
    logic signed [31:0] pos_q, pos_d;

    always_comb begin
        pos_d = pos_q;
        if (tick) pos_d = pos_q + 32'sd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pos_q <= 32'sd0;
        else        pos_q <= pos_d;
    end

    assign cmd_io.pos = pos_q;
`endif
endmodule

// File: tb/tb_acc_step_gen.sv
// tb/tb_acc_step_gen.sv - directed self-checking bench for acc_step_gen.
// Honours ACC_STEP_GEN_POS_EN when defined.
module tb_acc_step_gen;
    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   step_at[$];
    int   done_at[$];
    int   sl_at[$];

    acc_step_gen_if bus ();

    acc_step_gen dut (
        .clk    (clk),
        .reset  (reset),
        .cmd_io (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [31:0] dt, input logic [31:0] st);
        bus.load      = 1'b1;
        bus.dt_val    = dt;
        bus.steps_val = st;
        tick();
        bus.load      = 1'b0;
        bus.dt_val    = 32'hdead_beef;
        bus.steps_val = 32'h1234_5678;
    endtask

    // Records step/done edges relative to the last load edge (k = 1 is the first edge after it).
    task automatic observe(input int n);
        step_at.delete();
        done_at.delete();
        sl_at.delete();
        for (int k = 1; k <= n; k++) begin
            tick();
            if (bus.step === 1'b1) begin
                step_at.push_back(k);
                sl_at.push_back(int'(bus.steps_left));
            end
            if (bus.done === 1'b1) done_at.push_back(k);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        bus.load      = 1'b0;
        bus.dt_val    = 32'd0;
        bus.steps_val = 32'd0;
        reset = 1'b0;

        tick();
        tick();
        chk("rst step", {31'd0, bus.step}, 32'd0);
        chk("rst busy", {31'd0, bus.busy}, 32'd0);
        chk("rst done", {31'd0, bus.done}, 32'd0);
        chk("rst steps_left", bus.steps_left, 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("idle busy", {31'd0, bus.busy}, 32'd0);
        chk("idle step", {31'd0, bus.step}, 32'd0);
        chk("idle done", {31'd0, bus.done}, 32'd0);

        // Basic segment, then two identical reloads at N+76 and N+170.
        do_load(32'd20, 32'd3);
        chk("basic busy", {31'd0, bus.busy}, 32'd1);
        chk("basic sl0", bus.steps_left, 32'd3);
        for (int rep = 0; rep < 3; rep++) begin
            observe(70);
            chk("seg nsteps", step_at.size(), 32'd3);
            chk("seg step1", qget(step_at, 0), 32'd20);
            chk("seg step2", qget(step_at, 1), 32'd40);
            chk("seg step3", qget(step_at, 2), 32'd60);
            chk("seg sl1", qget(sl_at, 0), 32'd2);
            chk("seg sl2", qget(sl_at, 1), 32'd1);
            chk("seg sl3", qget(sl_at, 2), 32'd0);
            chk("seg ndone", done_at.size(), 32'd1);
            chk("seg done", qget(done_at, 0), 32'd61);
            chk("seg busy end", {31'd0, bus.busy}, 32'd0);
            if (rep == 0) begin
                for (int i = 0; i < 5; i++) tick();
                do_load(32'd20, 32'd3);
            end else if (rep == 1) begin
                for (int i = 0; i < 23; i++) tick();
                do_load(32'd20, 32'd3);
            end
        end

        // Preempt at N+30 with a shorter segment.
        do_load(32'd20, 32'd3);
        observe(29);
        chk("pre a nsteps", step_at.size(), 32'd1);
        chk("pre a step", qget(step_at, 0), 32'd20);
        chk("pre a ndone", done_at.size(), 32'd0);
        do_load(32'd5, 32'd2);
        chk("pre b sl", bus.steps_left, 32'd2);
        observe(20);
        chk("pre b nsteps", step_at.size(), 32'd2);
        chk("pre b step1", qget(step_at, 0), 32'd5);
        chk("pre b step2", qget(step_at, 1), 32'd10);
        chk("pre b ndone", done_at.size(), 32'd1);
        chk("pre b done", qget(done_at, 0), 32'd11);

        // steps_val = 0: immediate done, never busy.
        do_load(32'd7, 32'd0);
        chk("zero done", {31'd0, bus.done}, 32'd1);
        chk("zero busy", {31'd0, bus.busy}, 32'd0);
        chk("zero step", {31'd0, bus.step}, 32'd0);
        observe(5);
        chk("zero nsteps", step_at.size(), 32'd0);
        chk("zero ndone", done_at.size(), 32'd0);

        // dt_val = 0 behaves as 1.
        do_load(32'd0, 32'd4);
        observe(8);
        chk("dt0 nsteps", step_at.size(), 32'd4);
        chk("dt0 step1", qget(step_at, 0), 32'd1);
        chk("dt0 step4", qget(step_at, 3), 32'd4);
        chk("dt0 sl4", qget(sl_at, 3), 32'd0);
        chk("dt0 done", qget(done_at, 0), 32'd5);

        // Load coincides with the final step: step kept, done suppressed.
        do_load(32'd3, 32'd2);
        observe(5);
        chk("coin a step", qget(step_at, 0), 32'd3);
        do_load(32'd4, 32'd1);
        chk("coin step", {31'd0, bus.step}, 32'd1);
        chk("coin done", {31'd0, bus.done}, 32'd0);
        chk("coin sl", bus.steps_left, 32'd1);
        chk("coin busy", {31'd0, bus.busy}, 32'd1);
        observe(6);
        chk("coin b nsteps", step_at.size(), 32'd1);
        chk("coin b step", qget(step_at, 0), 32'd4);
        chk("coin b ndone", done_at.size(), 32'd1);
        chk("coin b done", qget(done_at, 0), 32'd5);

        // Asynchronous reset in the middle of a segment.
        do_load(32'd20, 32'd3);
        observe(29);
        chk("ar busy pre", {31'd0, bus.busy}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar busy", {31'd0, bus.busy}, 32'd0);
        chk("ar sl", bus.steps_left, 32'd0);
        chk("ar step", {31'd0, bus.step}, 32'd0);
`ifdef ACC_STEP_GEN_POS_EN
        chk("ar pos", bus.pos, 32'd0);
`endif
        tick();
        tick();
        reset = 1'b1;
        observe(40);
        chk("ar nsteps", step_at.size(), 32'd0);
        chk("ar ndone", done_at.size(), 32'd0);
        chk("ar busy end", {31'd0, bus.busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
